calc_input_fsm: RTL



---
 rtl/calc_input_fsm_pkg.sv | 39 +++
 rtl/calc_input_fsm_if.sv | 30 +++
 rtl/calc_input_fsm_dec_accum.sv | 16 +
 rtl/calc_input_fsm.sv | 133 +++++++++++++
 4 files changed

// File: rtl/calc_input_fsm_pkg.sv
// Shared definitions for the calculator front end: key codes, ALU opcodes and sequencer states.
// The button reader and ALU import this same package.
package calc_pkg;

    localparam logic [4:0] KEY_AC  = 5'h10;
    localparam logic [4:0] KEY_ADD = 5'h11;
    localparam logic [4:0] KEY_SUB = 5'h12;
    localparam logic [4:0] KEY_MUL = 5'h13;
    localparam logic [4:0] KEY_DIV = 5'h14;
    localparam logic [4:0] KEY_EQ  = 5'h15;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        S_A, S_OP, S_B, S_ISSUE, S_WAIT, S_RES, S_ERR
    } state_e;

    // Pending operator: MSB set means no chained operation follows the result.
    localparam logic [2:0] PEND_NONE = 3'b100;

    function automatic logic is_digit(logic [4:0] key);
        return key <= 5'd9;
    endfunction

    function automatic logic is_operator(logic [4:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    // ADD..DIV are consecutive codes 0x11..0x14, so low bits minus one give the opcode.
    function automatic opcode_e key_to_op(logic [4:0] key);
        return opcode_e'(key[1:0] - 2'd1);
    endfunction

endpackage

// File: rtl/calc_input_fsm_if.sv
// Key, ALU request/result and display signals of the calculator sequencer.
import calc_pkg::*;

interface calc_input_fsm_if #(
    parameter int unsigned WIDTH = 16
);
    logic [4:0]       i_key;
    logic             i_key_valid;
    logic             o_key_ready;
    logic [WIDTH-1:0] o_op_a;
    logic [WIDTH-1:0] o_op_b;
    opcode_e          o_opcode;
    logic             o_op_valid;
    logic             i_op_ready;
    logic [WIDTH-1:0] i_res;
    logic             i_res_err;
    logic             i_res_valid;
    logic [WIDTH-1:0] o_disp_value;
    logic             o_disp_err;

    modport master (
        input  i_key, i_key_valid, i_op_ready, i_res, i_res_err, i_res_valid,
        output o_key_ready, o_op_a, o_op_b, o_opcode, o_op_valid, o_disp_value, o_disp_err
    );

    modport slave (
        output i_key, i_key_valid, i_op_ready, i_res, i_res_err, i_res_valid,
        input  o_key_ready, o_op_a, o_op_b, o_opcode, o_op_valid, o_disp_value, o_disp_err
    );
endinterface

// File: rtl/calc_input_fsm_dec_accum.sv
// Decimal digit accumulator: next = cur*10 + digit, with overflow flag when it exceeds WIDTH bits.
module dec_accum #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH-1:0] next_o,
    output logic             ovf_o
);
    // Four extra bits hold cur*10+9 for any WIDTH-bit cur.
    logic [WIDTH+3:0] wide;

    assign wide   = ({4'b0, cur_i} * (WIDTH+4)'(10)) + (WIDTH+4)'(digit_i);
    assign next_o = wide[WIDTH-1:0];
    assign ovf_o  = |wide[WIDTH+3:WIDTH];
endmodule

// File: rtl/calc_input_fsm.sv
// Calculator front-end sequencer: builds operands from keys, issues ALU requests, chains results.
import calc_pkg::*;

module calc_input_fsm #(
    parameter int unsigned WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    calc_input_fsm_if.master bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    opcode_e          op_q, op_d;
    logic [2:0]       pend_q, pend_d;

    logic             key_ready, key_fire;
    logic [4:0]       key;
    logic [WIDTH-1:0] acc_cur, acc_next;
    logic             acc_ovf;

    assign key       = bus.i_key;
    assign key_ready = (state_q != S_ISSUE) && (state_q != S_WAIT);
    assign key_fire  = bus.i_key_valid && key_ready;
    assign acc_cur   = (state_q == S_B) ? b_q : a_q;

    dec_accum #(.WIDTH(WIDTH)) u_dec_accum (
        .cur_i   (acc_cur),
        .digit_i (key[3:0]),
        .next_o  (acc_next),
        .ovf_o   (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            pend_q  <= PEND_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        pend_d  = pend_q;

        if (key_fire && key == KEY_AC) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            pend_d  = PEND_NONE;
        end else begin
            case (state_q)
                S_A: begin
                    if (key_fire && is_digit(key) && !acc_ovf) begin
                        a_d = acc_next;
                    end else if (key_fire && is_operator(key)) begin
                        op_d    = key_to_op(key);
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (key_fire && is_digit(key)) begin
                        b_d     = WIDTH'(key[3:0]);
                        state_d = S_B;
                    end else if (key_fire && is_operator(key)) begin
                        op_d = key_to_op(key);
                    end
                end
                S_B: begin
                    if (key_fire && is_digit(key) && !acc_ovf) begin
                        b_d = acc_next;
                    end else if (key_fire && key == KEY_EQ) begin
                        pend_d  = PEND_NONE;
                        state_d = S_ISSUE;
                    end else if (key_fire && is_operator(key)) begin
                        pend_d  = {1'b0, key_to_op(key)};
                        state_d = S_ISSUE;
                    end
                end
                // A result arriving together with the request handshake is dropped.
                S_ISSUE: begin
                    if (bus.i_op_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_res_valid) begin
                        if (bus.i_res_err) begin
                            state_d = S_ERR;
                        end else begin
                            a_d = bus.i_res;
                            b_d = '0;
                            if (pend_q != PEND_NONE) begin
                                op_d    = opcode_e'(pend_q[1:0]);
                                state_d = S_OP;
                            end else begin
                                state_d = S_RES;
                            end
                        end
                    end
                end
                S_RES: begin
                    if (key_fire && is_digit(key)) begin
                        a_d     = WIDTH'(key[3:0]);
                        state_d = S_A;
                    end else if (key_fire && is_operator(key)) begin
                        op_d    = key_to_op(key);
                        state_d = S_OP;
                    end
                end
                S_ERR: ;
                default: state_d = S_A;
            endcase
        end
    end

    assign bus.o_key_ready  = key_ready;
    assign bus.o_op_valid   = (state_q == S_ISSUE);
    assign bus.o_op_a       = a_q;
    assign bus.o_op_b       = b_q;
    assign bus.o_opcode     = op_q;
    assign bus.o_disp_err   = (state_q == S_ERR);
    assign bus.o_disp_value = (state_q == S_ERR) ? '0 : ((state_q == S_B) ? b_q : a_q);
endmodule
